// File: rtl/csr_neighbor_fetch_if.sv
// csr_neighbor_fetch_if: request, graph-memory and neighbour-stream signals of the CSR neighbour fetcher
interface csr_neighbor_fetch_if #(parameter int PROC_BITS = 4);
  logic [31:0] req_vertex;
  logic req_valid, req_ready;
  logic [31+PROC_BITS:0] idx_addr;
  logic idx_validin;
  logic [31:0] rowidx_in;
  logic rowidx_valid_in;
  logic [31+PROC_BITS:0] data_addra, data_addrb;
  logic data_validina, data_validinb;
  logic [31:0] data_ina, data_inb;
  logic data_valid_ina, data_valid_inb;
  logic [31:0] nbr_data;
  logic nbr_valid, nbr_ready, nbr_last;
  logic done;
  logic [31:0] deg_out;
  logic err;
  modport slave (
    input req_vertex, req_valid, rowidx_in, rowidx_valid_in, data_ina, data_inb,
          data_valid_ina, data_valid_inb, nbr_ready,
    output req_ready, idx_addr, idx_validin, data_addra, data_addrb, data_validina,
           data_validinb, nbr_data, nbr_valid, nbr_last, done, deg_out, err
  );
  modport master (
    output req_vertex, req_valid, rowidx_in, rowidx_valid_in, data_ina, data_inb,
           data_valid_ina, data_valid_inb, nbr_ready,
    input req_ready, idx_addr, idx_validin, data_addra, data_addrb, data_validina,
          data_validinb, nbr_data, nbr_valid, nbr_last, done, deg_out, err
  );
endinterface

// File: rtl/csr_neighbor_fetch.sv
// csr_neighbor_fetch: reads a CSR row-pointer pair and streams the vertex's neighbour list through a credit-limited FIFO
module csr_neighbor_fetch #(
  parameter int PROC_BITS = 4,
  parameter int PROC_ID = 0,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk_in,
  input logic rst_in,
  csr_neighbor_fetch_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;
  localparam logic [PROC_BITS-1:0] PID = PROC_BITS'(PROC_ID);
  typedef enum logic [2:0] {IDLE, IDX_LO, IDX_HI, WAIT_IDX, STREAM, DRAIN} state_t;
  state_t state;
  logic [31:0] v, start_q, end_q, p, eq_n, deg;
  logic got_start, act, acc_a, acc_b, issue, deq, last_a, last_b;
  logic [CW-1:0] count, inflight, n_k, n_acc;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [32:0] mem [FIFO_DEPTH];
  always_comb begin
    act = state inside {WAIT_IDX, STREAM, DRAIN};
    acc_a = act && bus.data_valid_ina && inflight != '0;
    acc_b = act && bus.data_valid_inb && inflight > CW'(acc_a);
    n_acc = CW'(acc_a) + CW'(acc_b);
    n_k = (end_q - p > 32'd1) ? CW'(2) : CW'(1);
    issue = state == STREAM && count + inflight + n_k <= CW'(FIFO_DEPTH);
    deq = bus.nbr_valid && bus.nbr_ready;
    deg = end_q - start_q;
    last_a = eq_n == deg - 32'd1;
    last_b = eq_n + 32'(acc_a) == deg - 32'd1;
  end
  assign bus.nbr_valid = count != '0;
  assign bus.nbr_data = bus.nbr_valid ? mem[rd_ptr][31:0] : '0;
  assign bus.nbr_last = bus.nbr_valid && mem[rd_ptr][32];
  always_ff @(posedge clk_in) begin
    if (acc_a) mem[wr_ptr] <= {last_a, bus.data_ina};
    if (acc_b) mem[wr_ptr + AW'(acc_a)] <= {last_b, bus.data_inb};
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      v <= '0;
      start_q <= '0;
      end_q <= '0;
      p <= '0;
      eq_n <= '0;
      got_start <= 1'b0;
      count <= '0;
      inflight <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      bus.req_ready <= 1'b0;
      bus.idx_addr <= '0;
      bus.idx_validin <= 1'b0;
      bus.data_addra <= '0;
      bus.data_addrb <= '0;
      bus.data_validina <= 1'b0;
      bus.data_validinb <= 1'b0;
      bus.done <= 1'b0;
      bus.deg_out <= '0;
      bus.err <= 1'b0;
    end else begin
      bus.idx_addr <= '0;
      bus.idx_validin <= 1'b0;
      bus.data_addra <= '0;
      bus.data_addrb <= '0;
      bus.data_validina <= 1'b0;
      bus.data_validinb <= 1'b0;
      bus.done <= 1'b0;
      count <= count + n_acc - CW'(deq);
      inflight <= inflight + (issue ? n_k : '0) - n_acc;
      wr_ptr <= wr_ptr + AW'(n_acc);
      rd_ptr <= rd_ptr + AW'(deq);
      eq_n <= eq_n + 32'(n_acc);
      case (state)
        IDLE: begin
          bus.req_ready <= !(bus.req_valid && bus.req_ready);
          if (bus.req_valid && bus.req_ready) begin
            v <= bus.req_vertex;
            bus.idx_addr <= {PID, bus.req_vertex};
            bus.idx_validin <= 1'b1;
            got_start <= 1'b0;
            eq_n <= '0;
            state <= IDX_LO;
          end
        end
        IDX_LO: begin
          bus.idx_addr <= {PID, v + 32'd1};
          bus.idx_validin <= 1'b1;
          state <= IDX_HI;
        end
        IDX_HI: state <= WAIT_IDX;
        WAIT_IDX: begin
          if (bus.rowidx_valid_in && !got_start) begin
            start_q <= bus.rowidx_in;
            got_start <= 1'b1;
          end else if (bus.rowidx_valid_in) begin
            end_q <= bus.rowidx_in;
            p <= start_q;
            if (bus.rowidx_in > start_q) state <= STREAM;
            else begin
              bus.err <= bus.err || bus.rowidx_in < start_q;
              bus.done <= 1'b1;
              bus.deg_out <= '0;
              bus.req_ready <= 1'b1;
              state <= IDLE;
            end
          end
        end
        STREAM: begin
          if (issue) begin
            bus.data_addra <= {PID, p};
            bus.data_validina <= 1'b1;
            bus.data_addrb <= n_k == CW'(2) ? {PID, p + 32'd1} : '0;
            bus.data_validinb <= n_k == CW'(2);
            p <= p + 32'(n_k);
            state <= p + 32'(n_k) == end_q ? DRAIN : STREAM;
          end
        end
        DRAIN: begin
          if (inflight == '0 && count == '0) begin
            bus.done <= 1'b1;
            bus.deg_out <= deg;
            bus.req_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
